// File: rtl/jk_ff_using_sr.sv
// JK flip-flop built from an SR storage cell plus conversion logic, replicated WIDTH times.
// One-cycle latency from j/k to q. No backpressure; inputs are sampled only on the rising clk edge.
module jk_ff_using_sr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_r;

    // Conversion logic: S and R are never both high, because they are gated by opposite values of the present state.
    assign w_s = j & ~r_q;
    assign w_r = k &  r_q;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q[g] <= 1'b0;
                end else begin
                    // The S=R=1 case is unreachable, but the SR cell still treats it as hold.
                    case ({w_s[g], w_r[g]})
                        2'b10:   r_q[g] <= 1'b1;
                        2'b01:   r_q[g] <= 1'b0;
                        default: r_q[g] <= r_q[g];
                    endcase
                end
            end
        end
    endgenerate

    assign q   = r_q;
    assign q_n = ~r_q;

endmodule

// File: tb/tb_jk_ff_using_sr.sv
// Scoreboard bench for jk_ff_using_sr: one instance with WIDTH=1 and one with WIDTH=4.
// The expected state comes from the JK truth table, not from the SR conversion.
module tb_jk_ff_using_sr;

    logic       clk = 1'b0;
    logic       rst;
    logic       j;
    logic       k;
    logic       q;
    logic       q_n;
    logic       rst4;
    logic [3:0] j4;
    logic [3:0] k4;
    logic [3:0] q4;
    logic [3:0] qn4;

    logic       m_q;
    logic [3:0] m_q4;
    logic       exp_q[$];
    logic [3:0] exp_q4[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    jk_ff_using_sr #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .j   (j),
        .k   (k),
        .q   (q),
        .q_n (q_n)
    );

    jk_ff_using_sr #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .j   (j4),
        .k   (k4),
        .q   (q4),
        .q_n (qn4)
    );

    function automatic logic jk_next(input logic r, input logic jj, input logic kk, input logic cur);
        if (r)              return 1'b0;
        else if (jj && kk)  return ~cur;
        else if (jj)        return 1'b1;
        else if (kk)        return 1'b0;
        else                return cur;
    endfunction

    // Drive one WIDTH=1 cycle. The model result is queued, then sampling happens 1 ns after the edge.
    task automatic drive(input logic r, input logic jj, input logic kk);
        @(negedge clk);
        rst = r; j = jj; k = kk;
        m_q = jk_next(r, jj, kk, m_q);
        exp_q.push_back(m_q);
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic r, input logic [3:0] jj, input logic [3:0] kk);
        @(negedge clk);
        rst4 = r; j4 = jj; k4 = kk;
        for (int b = 0; b < 4; b++) m_q4[b] = jk_next(r, jj[b], kk[b], m_q4[b]);
        exp_q4.push_back(m_q4);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic e;
        // Inputs are applied before the first rising edge at 5 ns.
        rst = 1'b1; j = 1'b0; k = 1'b0;
        rst4 = 1'b1; j4 = 4'b0; k4 = 4'b0;
        m_q = 1'b0;
        m_q4 = 4'b0;
        exp_q.push_back(m_q);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL reset_q got=%b exp=%b", q, e); end
        checks++;
        if (q_n !== ~e) begin errors++; $display("FAIL reset_qn got=%b exp=%b", q_n, ~e); end
        drive(1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL reset_hold got=%b exp=%b", q, e); end
    endtask

    task automatic test_set_clear();
        logic e;
        logic [2:0] tj = 3'b010;
        logic [2:0] tk = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            drive(1'b0, tj[i], tk[i]);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL set_clear step=%0d got=%b exp=%b", 2 - i, q, e); end
            checks++;
            if (q_n !== ~e) begin errors++; $display("FAIL set_clear_qn step=%0d got=%b exp=%b", 2 - i, q_n, ~e); end
        end
    endtask

    task automatic test_toggle();
        logic e;
        // First toggle from q=0, then set q to 1 and toggle again.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b0, 1'b1, 1'b0);
            else        drive(1'b0, 1'b1, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL toggle step=%0d got=%b exp=%b", i, q, e); end
        end
    endtask

    task automatic test_hold_glitch();
        logic e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL hold step=%0d got=%b exp=%b", i, q, e); end
        end
        // Glitch j/k between edges; only the value at the edge counts.
        @(negedge clk);
        rst = 1'b0; j = 1'b0; k = 1'b1;
        #1 j = 1'b1; k = 1'b1;
        #1;
        checks++;
        if (q !== m_q) begin errors++; $display("FAIL glitch_mid got=%b exp=%b", q, m_q); end
        #1 j = 1'b0; k = 1'b0;
        m_q = jk_next(1'b0, 1'b0, 1'b0, m_q);
        exp_q.push_back(m_q);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL glitch_edge got=%b exp=%b", q, e); end
    endtask

    task automatic test_reset_priority();
        logic e;
        // Steps: set, reset while J=1, release with toggle, toggle, then reset during the toggle run, then resume.
        logic [5:0] tr = 6'b010010;
        logic [5:0] tj = 6'b111111;
        logic [5:0] tk = 6'b011111;
        for (int i = 5; i >= 0; i--) begin
            drive(tr[i], tj[i], tk[i]);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin errors++; $display("FAIL rst_prio step=%0d got=%b exp=%b", 5 - i, q, e); end
            checks++;
            if (q_n !== ~e) begin errors++; $display("FAIL rst_prio_qn step=%0d got=%b exp=%b", 5 - i, q_n, ~e); end
        end
    endtask

    task automatic test_width4();
        logic [3:0] e;
        logic [3:0] tj[5] = '{4'b0000, 4'b1010, 4'b1111, 4'b1100, 4'b0110};
        logic [3:0] tk[5] = '{4'b0000, 4'b0101, 4'b1111, 4'b0011, 4'b0110};
        logic       tr[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive4(tr[i], tj[i], tk[i]);
            e = exp_q4.pop_front();
            checks++;
            if (q4 !== e) begin errors++; $display("FAIL width4 step=%0d got=%b exp=%b", i, q4, e); end
            checks++;
            if (qn4 !== ~e) begin errors++; $display("FAIL width4_qn step=%0d got=%b exp=%b", i, qn4, ~e); end
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_toggle();
        test_hold_glitch();
        test_reset_priority();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
